mem_stage_sram_ctrl: RTL and testbench
======================================

// Module: mem_stage_sram_ctrl
// PURPOSE
//  MEM stage of the ARM 5-stage pipeline. Sits between EXE_Stage_Reg and WB_Stage.
//  - Non-memory instructions: passes ALU result/dest/wb_en through its own MEM/WB register.
//  - LDR/STR: performs a 32-bit access to external 16-bit SRAM as two halfword phases.
//  - Drives ready low while the access is in flight; the top level uses !ready as the global freeze.
// PARAMETERS
//  BASE_ADDR    1024  byte address mapped to SRAM word 0
//  SRAM_AW      18    SRAM halfword address width
//  WAIT_CYCLES  2     write-strobe cycles per phase; legal range >= 1; phase length = WAIT_CYCLES+1
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous reset, active-high
//  wb_en_in       in   1   writeback enable from EXE reg
//  mem_r_en_in    in   1   load request
//  mem_w_en_in    in   1   store request
//  alu_result_in  in   32  byte address (mem ops) or ALU result
//  st_val_in      in   32  store data (Rm value)
//  dest_in        in   4   destination register
//  sram_addr      out  SRAM_AW  halfword address
//  sram_dq_out    out  16  write data
//  sram_dq_oe     out  1   1 = drive sram_dq_out onto bus
//  sram_dq_in     in   16  read data
//  sram_we_n      out  1   active-low write strobe
//  ready          out  1   0 = freeze pipeline
//  wb_en          out  1   MEM/WB reg: writeback enable
//  mem_r_en       out  1   MEM/WB reg: selects mem_data for writeback
//  dest           out  4   MEM/WB reg: destination
//  alu_result     out  32  MEM/WB reg: ALU result
//  mem_data       out  32  MEM/WB reg: loaded word
// BEHAVIOUR
//  Reset: registered outputs all 0; state IDLE; sram_we_n=1; sram_dq_oe=0; sram_addr=0; ready=1.
//  Request: req = mem_r_en_in | mem_w_en_in. Both asserted counts as a read; store is ignored.
//  Address: widx = (alu_result_in - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits (wraps, no error).
//  Phase addresses: lo halfword at {widx,1'b0}; hi halfword at {widx,1'b1}.
//  FSM IDLE -> LO -> HI -> DONE -> IDLE; cnt counts 0..WAIT_CYCLES inside LO and HI.
//   IDLE: if req, go to LO with cnt=0; else stay in IDLE.
//   LO/HI: cnt++ each cycle; on cnt==WAIT_CYCLES, clear cnt and advance state.
//   DONE: one cycle, then IDLE unconditionally.
//  ready = !req | (state==DONE), combinational. During rst, ready=1.
//   Ready is low for 2*(WAIT_CYCLES+1)+1 cycles per access (7 at default).
//  Write:
//   - sram_dq_oe=1 throughout LO/HI; sram_dq_out = st_val_in[15:0] in LO, st_val_in[31:16] in HI.
//   - sram_we_n=0 while cnt<WAIT_CYCLES; 1 on the last cycle of each phase (hold).
//  Read:
//   - sram_we_n=1 and sram_dq_oe=0.
//   - sram_dq_in sampled on the last LO cycle into rd[15:0] and on the last HI cycle into rd[31:16].
//  MEM/WB register, updated every clk edge:
//   - ready=1: capture wb_en_in, mem_r_en_in, dest_in, alu_result_in; mem_data <= rd ({hi, lo}).
//   - ready=0: bubble. wb_en<=0 and mem_r_en<=0; dest, alu_result and mem_data hold.
//  Inputs are stable while ready=0 because the upstream pipeline is frozen.
//   A new request is accepted in IDLE on the cycle after DONE.
//  rst mid-access: abort immediately. Go to IDLE, cnt=0, sram_we_n=1, sram_dq_oe=0; no partial write completes further.
// TESTING
//  1. Non-mem op: wb_en_in=1, dest_in=3, alu_result_in=5.
//     -> ready stays 1; next cycle wb_en=1, dest=3, alu_result=5.
//  2. STR: alu_result_in=1028, st_val_in=32'hDEADBEEF, WAIT=2.
//     -> addr 2 with dq 16'hBEEF, then addr 3 with dq 16'hDEAD.
//     -> we_n low for 2 of every 3 cycles; ready low 7 cycles.
//  3. LDR from 1028 after test 2: sram_dq_in model returns the stored halfwords.
//     -> mem_data=32'hDEADBEEF, mem_r_en=1, wb_en=1 one edge after DONE.
//     -> wb_en=0 while ready=0.
//  4. Back-to-back LDR, LDR: second request enters IDLE on the cycle after DONE.
//     -> ready high exactly one cycle between the two 7-cycle stalls.
//  5. Assert rst during HI phase of a STR.
//     -> next cycle: state IDLE, we_n=1, dq_oe=0, ready=1, all outputs 0.
//  6. mem_r_en_in=mem_w_en_in=1, alu_result_in=1024.
//     -> read of addr 0/1 only; dq_oe never 1, we_n never 0.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage of the 5-stage ARM pipeline: passes ALU results through to WB and
// performs 32-bit LDR/STR accesses on an external 16-bit SRAM as two halfword phases.
module mem_stage_sram_ctrl #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en_in,
    input  logic               mem_r_en_in,
    input  logic               mem_w_en_in,
    input  logic [31:0]        alu_result_in,
    input  logic [31:0]        st_val_in,
    input  logic [3:0]         dest_in,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               ready,
    output logic               wb_en,
    output logic               mem_r_en,
    output logic [3:0]         dest,
    output logic [31:0]        alu_result,
    output logic [31:0]        mem_data
);
    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_wr;
    logic [15:0]        rd_lo;
    logic [15:0]        rd_hi;
    logic               req;
    logic               wr_req;
    logic [SRAM_AW-2:0] widx;
    logic [CW-1:0]      cnt_nx;
    logic               strobe_nx;

    assign req       = mem_r_en_in | mem_w_en_in;
    assign wr_req    = mem_w_en_in & ~mem_r_en_in;
    assign widx      = (SRAM_AW-1)'((alu_result_in - 32'(BASE_ADDR)) >> 2);
    assign cnt_nx    = cnt + 1'b1;
    assign strobe_nx = is_wr & (cnt_nx < LAST);
    assign ready     = rst | ~req | (state == DONE);

    // SRAM pins are registered from next-state decisions so they line up with state/cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_wr       <= 1'b0;
            rd_lo       <= '0;
            rd_hi       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            wb_en       <= 1'b0;
            mem_r_en    <= 1'b0;
            dest        <= '0;
            alu_result  <= '0;
            mem_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state       <= LO;
                        cnt         <= '0;
                        is_wr       <= wr_req;
                        sram_addr   <= {widx, 1'b0};
                        sram_dq_out <= st_val_in[15:0];
                        sram_dq_oe  <= wr_req;
                        sram_we_n   <= ~wr_req;
                    end
                end
                LO: begin
                    if (cnt == LAST) begin
                        state       <= HI;
                        cnt         <= '0;
                        if (!is_wr) rd_lo <= sram_dq_in;
                        sram_addr   <= {widx, 1'b1};
                        sram_dq_out <= st_val_in[31:16];
                        sram_we_n   <= ~is_wr;
                    end else begin
                        cnt       <= cnt_nx;
                        sram_we_n <= ~strobe_nx;
                    end
                end
                HI: begin
                    if (cnt == LAST) begin
                        state      <= DONE;
                        cnt        <= '0;
                        if (!is_wr) rd_hi <= sram_dq_in;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                    end else begin
                        cnt       <= cnt_nx;
                        sram_we_n <= ~strobe_nx;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // MEM/WB register: a stalled cycle becomes a bubble.
            if (ready) begin
                wb_en      <= wb_en_in;
                mem_r_en   <= mem_r_en_in;
                dest       <= dest_in;
                alu_result <= alu_result_in;
                mem_data   <= {rd_hi, rd_lo};
            end else begin
                wb_en    <= 1'b0;
                mem_r_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed pins plus random ops against an
// access-age model and a halfword reference memory.
module tb_mem_stage_sram_ctrl;
    localparam int W      = 2;
    localparam int BASE   = 1024;
    localparam int AW     = 18;
    localparam int LAST_A = 2*W + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
    logic [31:0] alu_result_in = '0, st_val_in = '0;
    logic [3:0]  dest_in = '0;
    logic [AW-1:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic sram_dq_oe, sram_we_n, ready, wb_en, mem_r_en;
    logic [3:0]  dest;
    logic [31:0] alu_result, mem_data;

    mem_stage_sram_ctrl #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .alu_result_in(alu_result_in), .st_val_in(st_val_in),
        .dest_in(dest_in), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n),
        .ready(ready), .wb_en(wb_en), .mem_r_en(mem_r_en), .dest(dest),
        .alu_result(alu_result), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // External SRAM: writes on any clock edge with the strobe low.
    logic [15:0] sram_mem [0:(1<<AW)-1];
    logic [15:0] ref_hw   [0:(1<<AW)-1];
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) if (sram_we_n === 1'b0) sram_mem[sram_addr] <= sram_dq_out;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age = cycles since the request was accepted (-1 when no access).
    int          age = -1;
    logic        m_wb = 1'b0, m_mr = 1'b0;
    logic [3:0]  m_dest = '0;
    logic [31:0] m_alu = '0, m_md = '0, last_rd = '0;
    int          a, off;
    logic        c_req, c_wr, in_lo, in_hi, e_ready, e_oe, e_we_n;
    logic [31:0] diff;
    logic [16:0] wi;
    logic [17:0] e_addr;
    logic [15:0] e_dq;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            c_req = mem_r_en_in | mem_w_en_in;
            c_wr  = mem_w_en_in & ~mem_r_en_in;
            diff  = alu_result_in - 32'(BASE);
            wi    = diff[18:2];
            a     = (age < 0 && c_req && !rst) ? 0 : age;
            in_lo = (a >= 1) && (a <= W + 1);
            in_hi = (a >= W + 2) && (a <= 2*W + 2);
            off   = in_hi ? a - (W + 2) : a - 1;
            e_ready = rst || !c_req || (a == LAST_A);
            e_oe    = (in_lo || in_hi) && c_wr;
            e_we_n  = !(e_oe && off < W);
            e_addr  = {wi, in_hi};
            e_dq    = in_hi ? st_val_in[31:16] : st_val_in[15:0];

            chk("ready", 32'(ready), 32'(e_ready));
            chk("we_n", 32'(sram_we_n), 32'(e_we_n));
            chk("dq_oe", 32'(sram_dq_oe), 32'(e_oe));
            if (in_lo || in_hi) chk("sram_addr", 32'(sram_addr), 32'(e_addr));
            if (e_oe) chk("dq_out", 32'(sram_dq_out), 32'(e_dq));
            chk("wb_en", 32'(wb_en), 32'(m_wb));
            chk("mem_r_en", 32'(mem_r_en), 32'(m_mr));
            chk("dest", 32'(dest), 32'(m_dest));
            chk("alu_result", alu_result, m_alu);
            chk("mem_data", mem_data, m_md);

            if (!e_we_n) ref_hw[e_addr] = e_dq;
            if (rst) begin
                age = -1; m_wb = 0; m_mr = 0; m_dest = '0; m_alu = '0; m_md = '0; last_rd = '0;
            end else begin
                if (a == 2*W + 2 && !c_wr) last_rd = {ref_hw[{wi, 1'b1}], ref_hw[{wi, 1'b0}]};
                if (e_ready) begin
                    m_wb = wb_en_in; m_mr = mem_r_en_in; m_dest = dest_in;
                    m_alu = alu_result_in; m_md = last_rd;
                end else begin
                    m_wb = 0; m_mr = 0;
                end
                age = (a < 0 || a == LAST_A) ? -1 : a + 1;
            end
        end
    end

    // Stimulus
    int low, we_low, oe_cnt, stall_wb;
    logic [AW-1:0] lo_addr, hi_addr;
    logic [15:0] lo_dq, hi_dq;
    logic snap_ready, snap_wb;
    logic [31:0] snap_md;

    task automatic set_in(input logic r, input logic w, input logic wb,
                          input logic [31:0] alu, input logic [31:0] st, input logic [3:0] d);
        mem_r_en_in = r; mem_w_en_in = w; wb_en_in = wb;
        alu_result_in = alu; st_val_in = st; dest_in = d;
    endtask

    task automatic issue(input logic r, input logic w, input logic wb,
                         input logic [31:0] alu, input logic [31:0] st, input logic [3:0] d);
        @(posedge clk); #1;
        set_in(r, w, wb, alu, st, d);
        low = 0; we_low = 0; oe_cnt = 0; stall_wb = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) begin snap_ready = ready; snap_wb = wb_en; snap_md = mem_data; end
            if (ready === 1'b1) break;
            low++;
            if (sram_we_n === 1'b0) we_low++;
            if (sram_dq_oe === 1'b1) oe_cnt++;
            if (low > 1 && wb_en !== 1'b0) stall_wb++;
            if (low == 2) begin lo_addr = sram_addr; lo_dq = sram_dq_out; end
            if (low == 2*W + 3) begin hi_addr = sram_addr; hi_dq = sram_dq_out; end
            if (k == 29) chk("stall_bound", 32'(low), 32'(LAST_A));
        end
    endtask

    task automatic nop();
        issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        logic [31:0] alu;
        int kind, k;
        for (int i = 0; i < (1<<AW); i++) begin sram_mem[i] = '0; ref_hw[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_wb", 32'(wb_en), 32'd0);
        chk("rst_md", mem_data, 32'd0);

        // Non-memory op
        issue(1'b0, 1'b0, 1'b1, 32'd5, 32'h0, 4'd3);
        chk("nm_stall", 32'(low), 32'd0);
        nop();
        chk("nm_wb", 32'(wb_en), 32'd1);
        chk("nm_dest", 32'(dest), 32'd3);
        chk("nm_alu", alu_result, 32'd5);

        // STR 1028
        issue(1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0);
        chk("str_stall", 32'(low), 32'd7);
        chk("str_we_low", 32'(we_low), 32'd4);
        chk("str_oe", 32'(oe_cnt), 32'd6);
        chk("str_lo_addr", 32'(lo_addr), 32'd2);
        chk("str_lo_dq", 32'(lo_dq), 32'hBEEF);
        chk("str_hi_addr", 32'(hi_addr), 32'd3);
        chk("str_hi_dq", 32'(hi_dq), 32'hDEAD);
        chk("sram2", 32'(sram_mem[2]), 32'hBEEF);
        chk("sram3", 32'(sram_mem[3]), 32'hDEAD);

        // LDR 1028
        issue(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 4'd7);
        chk("ldr_stall", 32'(low), 32'd7);
        chk("ldr_stall_wb", 32'(stall_wb), 32'd0);
        nop();
        chk("ldr_md", mem_data, 32'hDEADBEEF);
        chk("ldr_mr", 32'(mem_r_en), 32'd1);
        chk("ldr_wb", 32'(wb_en), 32'd1);
        chk("ldr_dest", 32'(dest), 32'd7);

        // Back-to-back loads
        issue(1'b0, 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 4'd0);
        issue(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 4'd1);
        issue(1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, 4'd2);
        chk("b2b_gap", 32'(snap_ready), 32'd0);
        chk("b2b_first_wb", 32'(snap_wb), 32'd1);
        chk("b2b_first_md", snap_md, 32'hDEADBEEF);
        chk("b2b_stall", 32'(low), 32'd7);
        nop();
        chk("b2b_md", mem_data, 32'hCAFEF00D);
        chk("b2b_dest", 32'(dest), 32'd2);

        // Reset during HI of a store
        @(posedge clk); #1;
        set_in(1'b0, 1'b1, 1'b0, 32'd1040, 32'h12345678, 4'd0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("hi_addr", 32'(sram_addr), 32'd9);
        chk("rst_hi_ready", 32'(ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        chk("abort_wb", 32'(wb_en), 32'd0);
        chk("abort_dest", 32'(dest), 32'd0);
        chk("abort_alu", alu_result, 32'd0);

        // Read and write both asserted: behaves as a read
        issue(1'b1, 1'b1, 1'b1, 32'd1024, 32'hFFFF0000, 4'd4);
        chk("both_oe", 32'(oe_cnt), 32'd0);
        chk("both_we", 32'(we_low), 32'd0);
        chk("both_lo_addr", 32'(lo_addr), 32'd0);
        chk("both_hi_addr", 32'(hi_addr), 32'd1);
        nop();
        chk("both_mr", 32'(mem_r_en), 32'd1);
        chk("both_md", mem_data, 32'd0);

        // Random traffic with occasional aborts
        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) alu = $urandom;
            else alu = 32'(BASE + 4 * int'($urandom_range(0, 31)) + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 24) == 0) begin
                @(posedge clk); #1;
                set_in(kind == 1 || kind == 3, kind >= 2, 1'($urandom), alu, $urandom, 4'($urandom));
                k = int'($urandom_range(1, 7));
                repeat (k) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end else begin
                issue(kind == 1 || kind == 3, kind >= 2, 1'($urandom), alu, $urandom, 4'($urandom));
            end
        end
        nop();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
